if_fetch_ctrl: RTL and testbench

- Instruction-fetch control stage. Owns the program-counter register and drives `pc_o` into the IF PC+4 adder; consumes that adder's result (`pc_plus4_i`) as the sequential next PC.
- Issues single-outstanding requests to instruction memory and captures returned instructions into the IF/ID pipeline register.
- Handles decode stalls through a one-entry hold buffer and EX-stage redirects (branch/jump), including discarding in-flight fetches.

---
 rtl/if_fetch_ctrl.sv | 160 ++++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch control: owns the PC, issues single-outstanding imem
// requests, fills the IF/ID register through a one-entry hold buffer.
//
// state   | meaning
// FETCH   | request at pc_o is presented; waiting for grant
// WAIT    | one request in flight; waiting for its response
// HOLD    | response parked in hold buffer; decode is stalled
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_o,
  input  logic [31:0] pc_plus4_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_stall_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_instr_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] req_pc;
  logic        hold_valid;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;
  logic        discard;

  logic        accepting;
  logic        gnt_ok;
  logic        rsp_take;
  logic [31:0] redir_pc;

  assign imem_addr_o = pc_o;
  assign accepting   = !ifid_valid_o || !id_stall_i;
  // a grant only counts against a request we are actually presenting
  assign gnt_ok      = imem_req_o && imem_gnt_i;
  assign rsp_take    = (state == S_WAIT) && imem_rvalid_i && !discard;
  assign redir_pc    = {redirect_pc_i[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_FETCH;
      pc_o         <= RESET_PC;
      req_pc       <= RESET_PC;
      imem_req_o   <= 1'b0;
      hold_valid   <= 1'b0;
      hold_pc      <= 32'h0;
      hold_instr   <= NOP_INSTR;
      discard      <= 1'b0;
      ifid_valid_o <= 1'b0;
      ifid_pc_o    <= 32'h0;
      ifid_instr_o <= NOP_INSTR;
      misalign_o   <= 1'b0;
    end else begin
      misalign_o <= redirect_i && (redirect_pc_i[1:0] != 2'b00);

      if (redirect_i) begin
        pc_o         <= redir_pc;
        ifid_valid_o <= 1'b0;
        ifid_instr_o <= NOP_INSTR;
        hold_valid   <= 1'b0;
        case (state)
          S_FETCH: begin
            if (gnt_ok) begin
              // the old-address request is already out; drop its response
              state      <= S_WAIT;
              discard    <= 1'b1;
              imem_req_o <= 1'b0;
            end else begin
              imem_req_o <= 1'b1;
            end
          end
          S_WAIT: begin
            if (imem_rvalid_i) begin
              state      <= S_FETCH;
              discard    <= 1'b0;
              imem_req_o <= 1'b1;
            end else begin
              discard    <= 1'b1;
            end
          end
          default: begin
            state      <= S_FETCH;
            imem_req_o <= 1'b1;
          end
        endcase
      end else begin
        // decode consumed the slot and nothing new arrives: bubble
        if (accepting && !rsp_take && (state != S_HOLD)) begin
          ifid_valid_o <= 1'b0;
          ifid_instr_o <= NOP_INSTR;
        end

        case (state)
          S_FETCH: begin
            if (gnt_ok) begin
              req_pc     <= pc_o;
              pc_o       <= pc_plus4_i;
              state      <= S_WAIT;
              imem_req_o <= 1'b0;
            end else begin
              imem_req_o <= 1'b1;
            end
          end
          S_WAIT: begin
            if (imem_rvalid_i) begin
              if (discard) begin
                discard    <= 1'b0;
                state      <= S_FETCH;
                imem_req_o <= 1'b1;
              end else if (accepting) begin
                ifid_valid_o <= 1'b1;
                ifid_pc_o    <= req_pc;
                ifid_instr_o <= imem_rdata_i;
                state        <= S_FETCH;
                imem_req_o   <= 1'b1;
              end else begin
                hold_valid <= 1'b1;
                hold_pc    <= req_pc;
                hold_instr <= imem_rdata_i;
                state      <= S_HOLD;
                imem_req_o <= 1'b0;
              end
            end
          end
          S_HOLD: begin
            if (accepting) begin
              ifid_valid_o <= hold_valid;
              ifid_pc_o    <= hold_pc;
              ifid_instr_o <= hold_instr;
              hold_valid   <= 1'b0;
              state        <= S_FETCH;
              imem_req_o   <= 1'b1;
            end
          end
          default: begin
            state      <= S_FETCH;
            imem_req_o <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed cycle-exact scenarios plus a randomized
// run checked against a program-order delivery model.
module tb_if_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        req;
  logic [31:0] addr;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  // memory model controls
  int          mem_lat = 1;
  int          gnt_pct = 100;
  bit          rand_lat = 1'b0;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  bit          inj = 1'b0;
  int          viol = 0;

  always #5 clk = ~clk;
  assign pc_plus4 = pc + 32'd4;

  if_fetch_ctrl #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .pc_o(pc), .pc_plus4_i(pc_plus4),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .id_stall_i(stall),
    .ifid_valid_o(ifid_valid), .ifid_pc_o(ifid_pc), .ifid_instr_o(ifid_instr),
    .misalign_o(misalign)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  // instruction memory: drives on the falling edge, response mem_lat cycles after grant
  always @(negedge clk) begin
    if (!rst_n) begin
      pend   = 1'b0;
      rvalid = 1'b0;
      gnt    = 1'b0;
    end else begin
      rvalid = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          rvalid = 1'b1;
          rdata  = instr_of(pend_addr);
          pend   = 1'b0;
        end else begin
          cnt = cnt - 1;
        end
      end
      if (inj) begin
        rvalid = 1'b1;
        rdata  = 32'hBAD0_BAD0;
        inj    = 1'b0;
      end
      gnt = 1'b0;
      if (req) begin
        if (pend) viol++;
        else if (int'($urandom_range(0, 99)) < gnt_pct) begin
          gnt       = 1'b1;
          pend      = 1'b1;
          pend_addr = addr;
          cnt       = (rand_lat ? int'($urandom_range(1, 4)) : mem_lat) - 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp %h", addr, 32'h0); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", req); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ifid_valid); end
    checks++; if (ifid_pc !== 32'h0) begin errors++; $display("FAIL reset_ifid_pc got %h exp 0", ifid_pc); end
    checks++; if (ifid_instr !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", ifid_instr, NOP); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", misalign); end
  endtask

  // zero-wait memory: PC advances every two cycles, IF/ID toggles valid/bubble
  task automatic test_stream();
    logic [31:0] exp_pc, exp_ipc;
    logic exp_req, exp_v;
    stall = 1'b0; mem_lat = 1; gnt_pct = 100; rand_lat = 1'b0;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_req = (i % 2 == 1);
      exp_pc  = 32'(4 * (i / 2));
      exp_v   = (i >= 3) && (i % 2 == 1);
      exp_ipc = 32'(4 * ((i - 3) / 2));
      checks++; if (req !== exp_req) begin errors++; $display("FAIL stream_req c%0d got %b exp %b", i, req, exp_req); end
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL stream_pc c%0d got %h exp %h", i, pc, exp_pc); end
      checks++; if (addr !== exp_pc) begin errors++; $display("FAIL stream_addr c%0d got %h exp %h", i, addr, exp_pc); end
      checks++; if (ifid_valid !== exp_v) begin errors++; $display("FAIL stream_valid c%0d got %b exp %b", i, ifid_valid, exp_v); end
      if (exp_v) begin
        checks++; if (ifid_pc !== exp_ipc) begin errors++; $display("FAIL stream_ifid_pc c%0d got %h exp %h", i, ifid_pc, exp_ipc); end
        checks++; if (ifid_instr !== instr_of(exp_ipc)) begin errors++; $display("FAIL stream_instr c%0d got %h exp %h", i, ifid_instr, instr_of(exp_ipc)); end
      end else begin
        checks++; if (ifid_instr !== NOP) begin errors++; $display("FAIL stream_nop c%0d got %h exp %h", i, ifid_instr, NOP); end
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b0; mem_lat = 1; gnt_pct = 100; rand_lat = 1'b0;
    do_reset();
    repeat (5) tick();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h4) begin errors++; $display("FAIL stall_pre got v=%b pc=%h exp v=1 pc=4", ifid_valid, ifid_pc); end
    stall = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL stall_req got %b exp 0", req); end
      checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h4) begin errors++; $display("FAIL stall_hold got v=%b pc=%h exp v=1 pc=4", ifid_valid, ifid_pc); end
      checks++; if (ifid_instr !== instr_of(32'h4)) begin errors++; $display("FAIL stall_instr got %h exp %h", ifid_instr, instr_of(32'h4)); end
      checks++; if (pc !== 32'hC) begin errors++; $display("FAIL stall_pc got %h exp %h", pc, 32'hC); end
    end
    stall = 1'b0;
    tick();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h8) begin errors++; $display("FAIL stall_release got v=%b pc=%h exp v=1 pc=8", ifid_valid, ifid_pc); end
    checks++; if (ifid_instr !== instr_of(32'h8)) begin errors++; $display("FAIL stall_release_instr got %h exp %h", ifid_instr, instr_of(32'h8)); end
    checks++; if (req !== 1'b1 || addr !== 32'hC) begin errors++; $display("FAIL stall_resume got req=%b addr=%h exp req=1 addr=c", req, addr); end
    repeat (2) tick();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'hC) begin errors++; $display("FAIL stall_next got v=%b pc=%h exp v=1 pc=c", ifid_valid, ifid_pc); end
  endtask

  task automatic test_redirect_wait();
    stall = 1'b0; mem_lat = 3; gnt_pct = 100; rand_lat = 1'b0;
    do_reset();
    repeat (2) tick();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL rw_in_wait got req=%b exp 0", req); end
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL rw_pc got %h exp 100", pc); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rw_misalign got %b exp 0", misalign); end
    for (int c = 4; c <= 8; c++) begin
      tick();
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rw_valid c%0d got %b exp 0", c, ifid_valid); end
      if (c == 5) begin
        checks++; if (req !== 1'b1 || addr !== 32'h100) begin errors++; $display("FAIL rw_req got req=%b addr=%h exp req=1 addr=100", req, addr); end
      end
    end
    tick();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h100) begin errors++; $display("FAIL rw_ifid got v=%b pc=%h exp v=1 pc=100", ifid_valid, ifid_pc); end
    checks++; if (ifid_instr !== instr_of(32'h100)) begin errors++; $display("FAIL rw_instr got %h exp %h", ifid_instr, instr_of(32'h100)); end
  endtask

  task automatic test_redirect_gnt();
    stall = 1'b0; mem_lat = 1; gnt_pct = 100; rand_lat = 1'b0;
    do_reset();
    tick();
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    checks++; if (pc !== 32'h200 || req !== 1'b0) begin errors++; $display("FAIL rg_wait got pc=%h req=%b exp pc=200 req=0", pc, req); end
    for (int c = 3; c <= 4; c++) begin
      tick();
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rg_valid c%0d got %b exp 0", c, ifid_valid); end
      if (c == 3) begin
        checks++; if (req !== 1'b1 || addr !== 32'h200) begin errors++; $display("FAIL rg_req got req=%b addr=%h exp req=1 addr=200", req, addr); end
      end
    end
    tick();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h200) begin errors++; $display("FAIL rg_ifid got v=%b pc=%h exp v=1 pc=200", ifid_valid, ifid_pc); end
    checks++; if (ifid_instr !== instr_of(32'h200)) begin errors++; $display("FAIL rg_instr got %h exp %h", ifid_instr, instr_of(32'h200)); end
    repeat (2) tick();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h204) begin errors++; $display("FAIL rg_next got v=%b pc=%h exp v=1 pc=204", ifid_valid, ifid_pc); end
  endtask

  task automatic test_misalign();
    stall = 1'b0; mem_lat = 1; gnt_pct = 100; rand_lat = 1'b0;
    do_reset();
    repeat (2) tick();
    redirect = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_pulse got %b exp 1", misalign); end
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL mis_pc got %h exp 100", pc); end
    checks++; if (req !== 1'b1 || ifid_valid !== 1'b0) begin errors++; $display("FAIL mis_state got req=%b v=%b exp req=1 v=0", req, ifid_valid); end
    tick();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_clear got %b exp 0", misalign); end
    tick();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h100) begin errors++; $display("FAIL mis_ifid got v=%b pc=%h exp v=1 pc=100", ifid_valid, ifid_pc); end
  endtask

  task automatic test_async_reset();
    stall = 1'b1; mem_lat = 3; gnt_pct = 100; rand_lat = 1'b0;
    do_reset();
    repeat (6) tick();
    checks++; if (ifid_valid !== 1'b1 || pc !== 32'h8) begin errors++; $display("FAIL ar_pre got v=%b pc=%h exp v=1 pc=8", ifid_valid, pc); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pc !== 32'h0 || req !== 1'b0) begin errors++; $display("FAIL ar_pc got pc=%h req=%b exp pc=0 req=0", pc, req); end
    checks++; if (ifid_valid !== 1'b0 || ifid_pc !== 32'h0 || ifid_instr !== NOP) begin errors++; $display("FAIL ar_ifid got v=%b pc=%h instr=%h exp v=0 pc=0 instr=%h", ifid_valid, ifid_pc, ifid_instr, NOP); end
    stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mem_lat = 1;
    rst_n = 1'b1;
    inj = 1'b1;
    tick();
    checks++; if (req !== 1'b1 || pc !== 32'h0 || ifid_valid !== 1'b0) begin errors++; $display("FAIL ar_restart got req=%b pc=%h v=%b exp req=1 pc=0 v=0", req, pc, ifid_valid); end
    repeat (2) tick();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0 || ifid_instr !== instr_of(32'h0)) begin errors++; $display("FAIL ar_first got v=%b pc=%h instr=%h exp v=1 pc=0 instr=%h", ifid_valid, ifid_pc, ifid_instr, instr_of(32'h0)); end
  endtask

  // Program-order model: every valid IF/ID slot must be the next expected PC;
  // decode consumption advances by 4, a redirect restarts at the aligned target.
  task automatic test_random();
    logic [31:0] exp_next, tgt;
    bit exp_mis, flushed, keep;
    int delivered;
    stall = 1'b0; gnt_pct = 70; rand_lat = 1'b1; viol = 0;
    do_reset();
    exp_next = 32'h0; exp_mis = 1'b0; flushed = 1'b0; keep = 1'b0; delivered = 0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      checks++; if (misalign !== exp_mis) begin errors++; $display("FAIL rnd_misalign n%0d got %b exp %b", n, misalign, exp_mis); end
      checks++; if (addr !== pc) begin errors++; $display("FAIL rnd_addr n%0d got %h exp %h", n, addr, pc); end
      if (flushed) begin
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rnd_flush n%0d got %b exp 0", n, ifid_valid); end
      end
      if (keep) begin
        checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL rnd_keep n%0d got %b exp 1", n, ifid_valid); end
      end
      if (ifid_valid === 1'b1) begin
        checks++; if (ifid_pc !== exp_next) begin errors++; $display("FAIL rnd_pc n%0d got %h exp %h", n, ifid_pc, exp_next); end
        checks++; if (ifid_instr !== instr_of(exp_next)) begin errors++; $display("FAIL rnd_instr n%0d got %h exp %h", n, ifid_instr, instr_of(exp_next)); end
      end
      stall = ($urandom_range(0, 99) < 30);
      redirect = ($urandom_range(0, 99) < 4);
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 4095));
      redirect_pc = tgt;
      if (redirect) begin
        exp_next = {tgt[31:2], 2'b00};
        exp_mis  = (tgt[1:0] != 2'b00);
        flushed  = 1'b1;
        keep     = 1'b0;
      end else begin
        exp_mis = 1'b0;
        flushed = 1'b0;
        keep    = (ifid_valid === 1'b1) && stall;
        if (ifid_valid === 1'b1 && !stall) begin
          exp_next = exp_next + 32'd4;
          delivered++;
        end
      end
    end
    stall = 1'b0; redirect = 1'b0;
    checks++; if (delivered < 50) begin errors++; $display("FAIL rnd_progress got %0d exp >= 50", delivered); end
    checks++; if (viol != 0) begin errors++; $display("FAIL rnd_outstanding got %0d exp 0", viol); end
    rand_lat = 1'b0; gnt_pct = 100;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_gnt();
    test_misalign();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
